// File: rtl/spi_port_multi_if.sv
// CPU-side bus and SPI pin bundle for spi_port_multi.
// slave is the SPI host's view; master is the CPU/bench view driving the bus and miso.
interface spi_port_multi_if #(
    parameter int CS_COUNT = 2
) ();
    logic                pe;
    logic                iorq;
    logic                wr;
    logic                rd;
    logic [7:0]          a;
    logic [7:0]          d;
    logic [7:0]          q;
    logic [CS_COUNT-1:0] cs;
    logic                ck;
    logic                mosi;
    logic                miso;
    logic                busy;

    modport slave (
        input  pe, iorq, wr, rd, a, d, miso,
        output q, cs, ck, mosi, busy
    );

    modport master (
        output pe, iorq, wr, rd, a, d, miso,
        input  q, cs, ck, mosi, busy
    );
endinterface

// File: rtl/spi_port_multi.sv
// Z80 I/O-mapped SPI mode-0 host: CS_COUNT chip selects, SCK = clock/(2*DIV), one-deep pending byte.
// Latency: 1 + 16*DIV + 1 clocks per byte; a request arriving with the pending slot full is dropped and flags overrun.
module spi_port_multi #(
    parameter int         CS_COUNT  = 2,
    parameter int         DIV       = 2,
    parameter logic [7:0] CS_PORT   = 8'hE7,
    parameter logic [7:0] DATA_PORT = 8'hEB,
    parameter logic [7:0] STAT_PORT = 8'hEF
) (
    input logic             clock,
    input logic             reset,
    spi_port_multi_if.slave bus
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, HI, LO, DONE} state_t;

    state_t              state, state_n;
    logic [DW-1:0]       div_cnt, div_n;
    logic [2:0]          bit_cnt, bit_n;
    logic [7:0]          shreg, sh_n;
    logic [7:0]          rx, rx_n;
    logic                pend, pend_n;
    logic [7:0]          pend_dat, pdat_n;
    logic                overrun, ovr_n;
    logic [CS_COUNT-1:0] cs_r, cs_n;
    logic                ck_r, ck_n;
    logic                mosi_r, mosi_n;
    logic                wr_seen, rd_seen;

    logic       wr_act, rd_act, wr_stb, rd_stb;
    logic       cs_wr, stat_rd, start;
    logic [7:0] start_dat;
    logic       div_last;
    logic [7:0] q_c;

    // One strobe per I/O cycle: the condition must be seen false by a pe sample before it can fire again
    assign wr_act    = ~bus.iorq & ~bus.wr;
    assign rd_act    = ~bus.iorq & ~bus.rd;
    assign wr_stb    = bus.pe & wr_act & ~wr_seen;
    assign rd_stb    = bus.pe & rd_act & ~rd_seen;
    assign cs_wr     = wr_stb & (bus.a == CS_PORT);
    assign stat_rd   = rd_stb & (bus.a == STAT_PORT);
    assign start     = (wr_stb | rd_stb) & (bus.a == DATA_PORT);
    assign start_dat = wr_stb ? bus.d : 8'hFF;
    assign div_last  = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= 8'hFF;
            rx       <= 8'hFF;
            pend     <= 1'b0;
            pend_dat <= 8'hFF;
            overrun  <= 1'b0;
            cs_r     <= '1;
            ck_r     <= 1'b0;
            mosi_r   <= 1'b1;
            wr_seen  <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            rx       <= rx_n;
            pend     <= pend_n;
            pend_dat <= pdat_n;
            overrun  <= ovr_n;
            cs_r     <= cs_n;
            ck_r     <= ck_n;
            mosi_r   <= mosi_n;
            if (bus.pe) begin
                wr_seen <= wr_act;
                rd_seen <= rd_act;
            end
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        rx_n    = rx;
        pend_n  = pend;
        pdat_n  = pend_dat;
        ovr_n   = overrun;
        cs_n    = cs_r;
        ck_n    = ck_r;
        mosi_n  = mosi_r;

        if (cs_wr)
            cs_n = bus.d[CS_COUNT-1:0];
        if (stat_rd)
            ovr_n = 1'b0;

        // miso is captured as ck rises; the shift exposes the next tx bit for the falling edge
        case (state)
            LOAD: begin
                state_n = HI;
                div_n   = '0;
                bit_n   = '0;
                ck_n    = 1'b1;
                sh_n    = {shreg[6:0], bus.miso};
            end
            HI: begin
                if (div_last) begin
                    state_n = LO;
                    div_n   = '0;
                    ck_n    = 1'b0;
                    mosi_n  = shreg[7];
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            LO: begin
                if (div_last) begin
                    div_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = DONE;
                        ck_n    = 1'b0;
                    end else begin
                        state_n = HI;
                        bit_n   = bit_cnt + 3'd1;
                        ck_n    = 1'b1;
                        sh_n    = {shreg[6:0], bus.miso};
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            DONE: begin
                rx_n = shreg;
                ck_n = 1'b0;
                if (pend) begin
                    state_n = LOAD;
                    sh_n    = pend_dat;
                    mosi_n  = pend_dat[7];
                    pend_n  = 1'b0;
                end else begin
                    state_n = IDLE;
                    mosi_n  = 1'b1;
                end
            end
            default: ;
        endcase

        // A request landing in DONE with no pending byte goes straight to LOAD so it is never stranded
        if (start) begin
            if (state == IDLE || (state == DONE && !pend)) begin
                state_n = LOAD;
                sh_n    = start_dat;
                mosi_n  = start_dat[7];
            end else if (!pend || state == DONE) begin
                pend_n = 1'b1;
                pdat_n = start_dat;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    always_comb begin
        q_c = 8'hFF;
        if (bus.a == DATA_PORT)
            q_c = rx;
        else if (bus.a == STAT_PORT)
            q_c = {bus.busy, pend, overrun, 5'b0};
    end

    assign bus.q    = q_c;
    assign bus.cs   = cs_r;
    assign bus.ck   = ck_r;
    assign bus.mosi = mosi_r;
    assign bus.busy = (state != IDLE) | pend;
endmodule
